// File: rtl/stream_demux_pkg.sv
// Shared types, constants and helpers for the stream_demux valid/ready demultiplexer.
package stream_demux_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam int unsigned DROP_CNT_W     = 16;

    typedef logic [DATA_W_DEFAULT-1:0] data_t;

    // True when a select value addresses an existing output channel.
    function automatic logic is_sel_valid(input int unsigned sel, input int unsigned n_out);
        return (sel < n_out);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: holds a single beat until its consumer accepts it.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_free_c
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Load wins over drain so a same-cycle drain+load keeps the slot full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_free_c = ~r_valid | i_ready;

endmodule

// File: rtl/stream_demux.sv
// Valid/ready 1-to-N stream demultiplexer with a one-entry slot per output channel.
// Optional drop counter for out-of-range selects: define STREAM_DEMUX_DROP_CNT_EN.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int unsigned N_OUT = 4,
    parameter  int unsigned W     = 8,
    localparam int unsigned SEL_W = $clog2(N_OUT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_data,
    input  logic [SEL_W-1:0]   in_sel,
    output logic [N_OUT-1:0]   out_valid,
    input  logic [N_OUT-1:0]   out_ready,
    output logic [N_OUT*W-1:0] out_data
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    localparam int unsigned N_PAD = 32'(1) << SEL_W;

    logic             w_sel_ok;
    logic             w_accept;
    logic [N_OUT-1:0] w_free;
    logic [N_OUT-1:0] w_load;
    logic [N_PAD-1:0] w_free_pad;

    assign w_sel_ok = is_sel_valid(32'(in_sel), N_OUT);

    // Unused select codes read as always free so out-of-range beats are swallowed.
    for (genvar p = 0; p < N_PAD; p++) begin : g_pad
        if (p < N_OUT) begin : g_real
            assign w_free_pad[p] = w_free[p];
        end else begin : g_void
            assign w_free_pad[p] = 1'b1;
        end
    end

    assign in_ready = rst_n & w_free_pad[in_sel];
    assign w_accept = in_valid & in_ready & w_sel_ok;

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        assign w_load[k] = w_accept & (in_sel == SEL_W'(k));

        demux_slot #(
            .W (W)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_load   (w_load[k]),
            .i_data   (in_data),
            .i_ready  (out_ready[k]),
            .o_valid  (out_valid[k]),
            .o_data   (out_data[k*W +: W]),
            .o_free_c (w_free[k])
        );
    end

`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic                  w_drop;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    assign w_drop = in_valid & in_ready & ~w_sel_ok;

    // Saturating count of beats consumed with an out-of-range select.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: 4-channel main instance plus a 3-channel instance for drops.
module tb_stream_demux;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;

    logic        in_valid3;
    logic        in_ready3;
    logic [1:0]  in_sel3;
    logic [2:0]  out_valid3;
    logic [2:0]  out_ready3;
    logic [23:0] out_data3;
`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [15:0] drop_cnt;
    logic [15:0] drop_cnt3;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q [4][$];

    stream_demux #(.N_OUT(4), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    stream_demux #(.N_OUT(3), .W(8)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_data   (in_data),
        .in_sel    (in_sel3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat; record the expectation at the handshake; return stall cycles.
    task automatic push(input logic [7:0] d, input logic [1:0] s, output int stalls);
        bit done;
        stalls   = 0;
        done     = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        while (!done && stalls < 20) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q[s].push_back(d);
                done = 1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check("push timeout", 32'(stalls), 32'(0));
    endtask

    // Monitor: every completed output handshake is checked against the channel queue.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    check($sformatf("sb ch%0d has expectation", k), 32'(exp_q[k].size() != 0), 32'(1));
                    if (exp_q[k].size() != 0) begin
                        e = exp_q[k].pop_front();
                        check($sformatf("sb ch%0d data", k), 32'(out_data[k*8 +: 8]), 32'(e));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int st_sum;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_sel     = 2'd0;
        out_ready  = 4'hF;
        in_valid3  = 1'b0;
        in_sel3    = 2'd0;
        out_ready3 = 3'b111;
        tick();
        tick();
        check("rst out_valid", 32'(out_valid), 32'h0);
        check("rst out_data", out_data, 32'h0);
        check("rst in_ready", 32'(in_ready), 32'h0);
        rst_n = 1'b1;

        // 1: single beat to channel 2
        push(8'h11, 2'd2, st);
        check("t1 out_valid", 32'(out_valid), 32'h4);
        check("t1 out_data", out_data, 32'h0011_0000);
        tick();
        check("t1 drained", 32'(out_valid), 32'h0);

        // 2: back-pressure on channel 1
        out_ready = 4'b1101;
        push(8'hA0, 2'd1, st);
        in_valid = 1'b1;
        in_data  = 8'hA1;
        in_sel   = 2'd1;
        @(negedge clk);
        check("t2 in_ready blocked", 32'(in_ready), 32'h0);
        check("t2 held data", 32'(out_data[15:8]), 32'hA0);
        tick();
        check("t2 still held", 32'(out_data[15:8]), 32'hA0);
        out_ready = 4'hF;
        push(8'hA1, 2'd1, st);
        check("t2 reload stall", 32'(st), 32'h0);
        check("t2 reload valid", 32'(out_valid), 32'h2);
        check("t2 reload data", 32'(out_data[15:8]), 32'hA1);
        tick();

        // 3: full throughput on channel 3
        st_sum = 0;
        for (int i = 0; i < 16; i++) begin
            push(8'(i), 2'd3, st);
            st_sum += st;
        end
        check("t3 stalls", 32'(st_sum), 32'h0);
        tick();
        tick();
        check("t3 sb drained", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 32'h0);

        // 4: no head-of-line blocking
        out_ready = 4'b1110;
        push(8'h77, 2'd0, st);
        push(8'h55, 2'd1, st);
        check("t4 stall", 32'(st), 32'h0);
        check("t4 out_valid", 32'(out_valid), 32'h3);
        check("t4 ch1 data", 32'(out_data[15:8]), 32'h55);

        // 5: reset while channels 0 and 2 are full
        out_ready = 4'b1010;
        push(8'h22, 2'd2, st);
        check("t5 full", 32'(out_valid), 32'h5);
        rst_n = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        check("t5 out_valid", 32'(out_valid), 32'h0);
        check("t5 out_data", out_data, 32'h0);
        check("t5 in_ready", 32'(in_ready), 32'h0);
        rst_n     = 1'b1;
        out_ready = 4'hF;
        push(8'h33, 2'd0, st);
        check("t5 post-reset", 32'(out_valid), 32'h1);
        tick();

        // 6: out-of-range select on the 3-channel instance
        in_valid3 = 1'b1;
        in_sel3   = 2'd3;
        in_data   = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6 in_ready", 32'(in_ready3), 32'h1);
            tick();
            check("t6 no valid", 32'(out_valid3), 32'h0);
        end
        in_valid3 = 1'b0;
`ifdef STREAM_DEMUX_DROP_CNT_EN
        check("t6 drop_cnt", 32'(drop_cnt3), 32'h3);
        check("t6 main drop_cnt", 32'(drop_cnt), 32'h0);
`endif
        in_valid3 = 1'b1;
        in_sel3   = 2'd1;
        in_data   = 8'h99;
        tick();
        in_valid3 = 1'b0;
        check("t6 valid sel", 32'(out_valid3), 32'h2);
        check("t6 valid data", 32'(out_data3), 32'h0000_9900);
        tick();
        check("t6 drained", 32'(out_valid3), 32'h0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        force dut3.r_drop_cnt = 16'hFFFE;
        tick();
        release dut3.r_drop_cnt;
        check("t6 forced", 32'(drop_cnt3), 32'hFFFE);
        in_valid3 = 1'b1;
        in_sel3   = 2'd3;
        tick();
        tick();
        tick();
        in_valid3 = 1'b0;
        check("t6 saturate", 32'(drop_cnt3), 32'hFFFF);
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
